// File: rtl/spi_rx_pkg.sv
// Shared types and default frame geometry for the camera SPI receive path.
package spi_rx_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LINES      = 4;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 360;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [DEF_LINES-1:0]    packet_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_DONE
  } rx_state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Two-flop synchronizer for asynchronous link inputs with a registered
// rising-edge detector per bit.
module spi_rx_sync #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_out
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {WIDTH{RESET_VAL}};
      sync <= {WIDTH{RESET_VAL}};
      prev <= {WIDTH{RESET_VAL}};
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign sync_out = sync;
  assign rise_out = sync & ~prev;

endmodule

// File: rtl/spi_pixel_receiver.sv
// Camera SPI link receiver: deserializes LINES-pixel packets and replays them as a
// valid/ready pixel stream with frame position. Define SPI_RX_STATS_EN for event counters.
module spi_pixel_receiver
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINES      = DEF_LINES,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  frame_sync_in,
  output logic                  pixel_valid_out,
  input  logic                  pixel_ready_in,
  output logic [DATA_WIDTH-1:0] pixel_data_out,
  output logic [9:0]            pixel_hcount_out,
  output logic [8:0]            pixel_vcount_out,
  output logic                  pixel_last_out,
  output logic                  pixel_first_out,
  output logic                  overrun_out,
  output logic                  frame_err_out
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]           overrun_cnt_out,
  output logic [15:0]           frame_err_cnt_out
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(LINES - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]       V_LAST   = 9'(V_ACTIVE - 1);

  logic             dclk_rise;
  logic             dclk_level_unused;
  logic             cs_sync;
  logic             cs_rise_unused;
  logic [LINES-1:0] data_sync;
  logic [LINES-1:0] data_rise_unused;
  logic             vsync_rise;
  logic             vsync_level_unused;

  // cs resets to the deselected level so a reset release never looks like a packet start
  spi_rx_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_dclk (
    .clk(clk_in), .rst_n(rst_in), .async_in(chip_clk_in),
    .sync_out(dclk_level_unused), .rise_out(dclk_rise)
  );

  spi_rx_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk_in), .rst_n(rst_in), .async_in(chip_sel_in),
    .sync_out(cs_sync), .rise_out(cs_rise_unused)
  );

  spi_rx_sync #(.WIDTH(LINES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(clk_in), .rst_n(rst_in), .async_in(chip_data_in),
    .sync_out(data_sync), .rise_out(data_rise_unused)
  );

  spi_rx_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_vsync (
    .clk(clk_in), .rst_n(rst_in), .async_in(frame_sync_in),
    .sync_out(vsync_level_unused), .rise_out(vsync_rise)
  );

  rx_state_t state, state_next;
  logic [CNT_W-1:0]                  bit_cnt;
  logic [LINES-1:0][DATA_WIDTH-1:0]  shift_reg;
  logic [LINES-1:0][DATA_WIDTH-1:0]  hold_reg;
  logic                              hold_full;
  logic [IDX_W-1:0]                  pix_idx;
  logic                              first_armed;
  logic                              xfer;
  logic                              hold_free;
  logic shift_en, cnt_clr, load_pkt, drop_pkt, err_set;

  assign xfer      = hold_full && pixel_ready_in;
  assign hold_free = !hold_full || (xfer && (pix_idx == PIX_LAST));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= RX_IDLE;
    else         state <= state_next;
  end

  // A cs release with no bits shifted is a packet gap, not a truncated packet
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    load_pkt   = 1'b0;
    drop_pkt   = 1'b0;
    err_set    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!cs_sync) begin
          state_next = RX_SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      RX_SHIFT: begin
        if (cs_sync) begin
          err_set    = (bit_cnt != '0);
          state_next = RX_IDLE;
        end else if (dclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_next = RX_DONE;
        end
      end
      RX_DONE: begin
        load_pkt = hold_free;
        drop_pkt = !hold_free;
        if (!cs_sync) begin
          state_next = RX_SHIFT;
          cnt_clr    = 1'b1;
        end else begin
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) begin
        for (int k = 0; k < LINES; k++)
          shift_reg[k] <= {shift_reg[k][DATA_WIDTH-2:0], data_sync[k]};
      end
    end
  end

  // A load on the final transfer cycle refills the holding reg with no bubble
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_reg      <= '0;
      hold_full     <= 1'b0;
      pix_idx       <= '0;
      overrun_out   <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      if (load_pkt) begin
        hold_reg  <= shift_reg;
        hold_full <= 1'b1;
        pix_idx   <= '0;
      end else if (xfer) begin
        if (pix_idx == PIX_LAST) begin
          hold_full <= 1'b0;
          pix_idx   <= '0;
        end else begin
          pix_idx <= pix_idx + 1'b1;
        end
      end
      if (drop_pkt) overrun_out   <= 1'b1;
      if (err_set)  frame_err_out <= 1'b1;
    end
  end

  // Frame sync outranks a same-cycle advance so the next pixel always lands at (0,0)
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_hcount_out <= '0;
      pixel_vcount_out <= '0;
      first_armed      <= 1'b0;
    end else if (vsync_rise) begin
      pixel_hcount_out <= '0;
      pixel_vcount_out <= '0;
      first_armed      <= 1'b1;
    end else if (xfer) begin
      first_armed <= 1'b0;
      if (pixel_hcount_out == H_LAST) begin
        pixel_hcount_out <= '0;
        pixel_vcount_out <= (pixel_vcount_out == V_LAST) ? '0 : pixel_vcount_out + 1'b1;
      end else begin
        pixel_hcount_out <= pixel_hcount_out + 1'b1;
      end
    end
  end

  assign pixel_valid_out = hold_full;
  assign pixel_data_out  = hold_full ? hold_reg[pix_idx] : '0;
  assign pixel_first_out = hold_full && first_armed;
  assign pixel_last_out  = hold_full && (pixel_hcount_out == H_LAST) &&
                           (pixel_vcount_out == V_LAST);

`ifdef SPI_RX_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overrun_cnt_out   <= '0;
      frame_err_cnt_out <= '0;
    end else begin
      if (drop_pkt && (overrun_cnt_out != 16'hFFFF))  overrun_cnt_out   <= overrun_cnt_out + 1'b1;
      if (err_set && (frame_err_cnt_out != 16'hFFFF)) frame_err_cnt_out <= frame_err_cnt_out + 1'b1;
    end
  end
`endif

endmodule
